demux_capture_16b: RTL and testbench
====================================

# demux_capture_16b

Dual-lane 16-bit capture buffer placed directly downstream of the 16-bit 1:2 demultiplexer. It takes both demux outputs plus the same select line, pushes only the live lane's word into that lane's small FIFO, and presents each lane to its consumer through a valid/ready handshake. This decouples the two demux destinations from the producer's timing and shows backpressure on the selected lane.

## Interface
- DEPTH, 2, entries per lane FIFO; power of two, 2 or 4
- i_Clk  in  1  clock; all state updates on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Valid  in  1  a word is present on the demux outputs this cycle
- i_Sel  in  1  demux select for this cycle; 0 = lane 0, 1 = lane 1
- i_X0  in  16  demux output 0
- i_X1  in  16  demux output 1
- o_Ready  out  1  selected lane can accept a word; combinational: !full[i_Sel]
- o_Vld0, o_Vld1  out  1 each  lane FIFO non-empty
- o_D0, o_D1  out  16 each  lane FIFO head word; 16'h0000 when empty
- i_Rdy0, i_Rdy1  in  1 each  consumer accepts head this cycle
- o_Cnt0, o_Cnt1  out  clog2(DEPTH+1) each  lane occupancy
- o_Drop0, o_Drop1  out  8 each  saturating drop counters (only with CAPTURE_DROP_CNT_EN)

## Operation
- Per-lane state from occupancy: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
- Push: i_Valid && o_Ready → write i_X[i_Sel] at lane i_Sel write pointer; pointer +1 mod DEPTH; count +1. Unselected lane's input is ignored (demux drives it 0).
- Drop: i_Valid && !o_Ready → word discarded; no state change except drop counter.
- Pop: o_VldN && i_RdyN → read pointer +1 mod DEPTH; count −1. i_RdyN while empty: no effect.
- Simultaneous push and pop, same lane, PARTIAL: count unchanged, both pointers advance.
- Push and pop on FULL lane: push refused (o_Ready=0 from current full), pop proceeds; no pass-through.
- Push to EMPTY lane: no bypass; word appears on o_DN the following cycle.
- Lanes are independent: a pop on lane 0 and push on lane 1 in one cycle both take effect.
- Pointers wrap silently; full/empty determined by count, never by pointer compare.
- FIFO order preserved per lane.

## Timing
- Reset (i_Rst_n low, asynchronous, any cycle incl. mid-transfer): pointers 0, counts 0, o_Vld0/1=0, o_D0/1=16'h0000, o_Cnt0/1=0, o_Drop0/1=0, o_Ready=1; stored words lost. Release sampled synchronously on next rising edge.
- Push-to-valid latency: 1 cycle. Pop-to-next-head: 1 cycle (head updates same edge as pop).
- o_Ready, o_VldN, o_DN, o_CntN are functions of registered state (o_Ready also of i_Sel); no path from i_RdyN to o_Ready.
- Full throughput: one push and one pop per lane per cycle.

## Configuration
- CAPTURE_DROP_CNT_EN defined: o_Drop0/o_Drop1 present; lane i_Sel counter increments on each drop, saturates at 8'hFF, cleared only by reset.
- Undefined: ports and counters absent; drops are silent; all other behaviour identical.

## Test plan
- Reset then idle: all outputs 0, o_Ready=1 for both i_Sel values; assert i_Rst_n low mid-stream with lane 0 at cnt=1 → o_Vld0=0, o_Cnt0=0 immediately.
- Push 16'hA5A5 (i_Sel=0, i_X0=16'hA5A5, i_X1=0), i_Rdy0=0 → next cycle o_Vld0=1, o_D0=16'hA5A5, o_Cnt0=1; lane 1 untouched.
- DEPTH=2, push 16'h0001, 16'h0002, 16'h0003 to lane 1 with i_Rdy1=0 → o_Cnt1=2, o_Ready=0 on third, third word dropped (o_Drop1=1 with macro); then i_Rdy1=1 → pops 0001, 0002 in order, o_Vld1=0.
- Lane 0 PARTIAL, push and pop same cycle for 8 cycles (values 0x10..0x17) → o_Cnt0 stays 1, outputs in order, pointers wrap cleanly.
- Lane 0 FULL, i_Rdy0=1 and push to lane 0 same cycle → pop occurs, push dropped, o_Cnt0=1.
- With macro: 300 drops on lane 0 → o_Drop0=8'hFF, o_Drop1=0.

Source files
------------

// File: rtl/demux_capture_16b_if.sv
// demux_capture_16b_if: producer/consumer bus for demux_capture_16b.
// Drop counter signals exist only when CAPTURE_DROP_CNT_EN is defined.
interface demux_capture_16b_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          i_Valid;
  logic          i_Sel;
  logic [15:0]   i_X0;
  logic [15:0]   i_X1;
  logic          o_Ready;
  logic          o_Vld0;
  logic          o_Vld1;
  logic [15:0]   o_D0;
  logic [15:0]   o_D1;
  logic          i_Rdy0;
  logic          i_Rdy1;
  logic [CW-1:0] o_Cnt0;
  logic [CW-1:0] o_Cnt1;
`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0]    o_Drop0;
  logic [7:0]    o_Drop1;
`endif
  modport master (
    output i_Valid, i_Sel, i_X0, i_X1, i_Rdy0, i_Rdy1,
    input  o_Ready, o_Vld0, o_Vld1, o_D0, o_D1, o_Cnt0, o_Cnt1
`ifdef CAPTURE_DROP_CNT_EN
    , input o_Drop0, o_Drop1
`endif
  );
  modport slave (
    input  i_Valid, i_Sel, i_X0, i_X1, i_Rdy0, i_Rdy1,
    output o_Ready, o_Vld0, o_Vld1, o_D0, o_D1, o_Cnt0, o_Cnt1
`ifdef CAPTURE_DROP_CNT_EN
    , output o_Drop0, o_Drop1
`endif
  );
endinterface

// File: rtl/demux_capture_16b.sv
// demux_capture_16b: dual-lane capture FIFOs behind a 1:2 demux with valid/ready per lane.
// Optional CAPTURE_DROP_CNT_EN adds saturating per-lane drop counters.
module demux_capture_16b #(
  parameter int DEPTH = 2
) (
  input logic               i_Clk,
  input logic               i_Rst_n,
  demux_capture_16b_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [15:0]   mem_q [2][DEPTH];
  logic [15:0]   mem_d [2][DEPTH];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [15:0]   x [2];
  logic [1:0]    full, vld, push, pop, rdy;
  logic          ready;
  assign x[0] = bus.i_X0;
  assign x[1] = bus.i_X1;
  assign rdy  = {bus.i_Rdy1, bus.i_Rdy0};
  // Full/empty come from occupancy only, so pointers may wrap freely.
  assign full  = {cnt_q[1] == CW'(DEPTH), cnt_q[0] == CW'(DEPTH)};
  assign vld   = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign ready = !full[bus.i_Sel];
  assign push  = {bus.i_Valid && ready && bus.i_Sel, bus.i_Valid && ready && !bus.i_Sel};
  assign pop   = vld & rdy;
  always_comb begin
    mem_d = mem_q;
    for (int l = 0; l < 2; l++) begin
      wp_d[l]  = wp_q[l] + AW'(push[l]);
      rp_d[l]  = rp_q[l] + AW'(pop[l]);
      cnt_d[l] = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
      if (push[l]) mem_d[l][wp_q[l]] = x[l];
    end
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wp_q  <= '{default: '0};
      rp_q  <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: a zero count masks stale words.
  always_ff @(posedge i_Clk) mem_q <= mem_d;
  assign bus.o_Ready = ready;
  assign bus.o_Vld0  = vld[0];
  assign bus.o_Vld1  = vld[1];
  assign bus.o_D0    = vld[0] ? mem_q[0][rp_q[0]] : 16'h0000;
  assign bus.o_D1    = vld[1] ? mem_q[1][rp_q[1]] : 16'h0000;
  assign bus.o_Cnt0  = cnt_q[0];
  assign bus.o_Cnt1  = cnt_q[1];
`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_q [2];
  logic [7:0] drop_d [2];
  always_comb begin
    for (int l = 0; l < 2; l++)
      drop_d[l] = drop_q[l] + 8'(bus.i_Valid && !ready && (bus.i_Sel == 1'(l)) && drop_q[l] != 8'hFF);
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) drop_q <= '{default: '0};
    else drop_q <= drop_d;
  end
  assign bus.o_Drop0 = drop_q[0];
  assign bus.o_Drop1 = drop_q[1];
`endif
endmodule

// File: tb/tb_demux_capture_16b.sv
// tb_demux_capture_16b: queue-based reference model with per-cycle compare, directed
// literal checks and randomized traffic for demux_capture_16b.
module tb_demux_capture_16b;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m0[$];
  logic [15:0] m1[$];
  int md0 = 0;
  int md1 = 0;
  demux_capture_16b_if #(.DEPTH(DEPTH)) bus ();
  demux_capture_16b #(.DEPTH(DEPTH)) dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: lane queues updated from the inputs present at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0.delete();
      m1.delete();
      md0 = 0;
      md1 = 0;
    end else begin
      automatic bit f0 = (m0.size() == DEPTH);
      automatic bit f1 = (m1.size() == DEPTH);
      if (m0.size() > 0 && bus.i_Rdy0) void'(m0.pop_front());
      if (m1.size() > 0 && bus.i_Rdy1) void'(m1.pop_front());
      if (bus.i_Valid && !bus.i_Sel) begin
        if (!f0) m0.push_back(bus.i_X0);
        else if (md0 < 255) md0++;
      end
      if (bus.i_Valid && bus.i_Sel) begin
        if (!f1) m1.push_back(bus.i_X1);
        else if (md1 < 255) md1++;
      end
    end
  end
  always @(negedge clk) begin
    chk("vld0", 32'(bus.o_Vld0), 32'(m0.size() > 0));
    chk("vld1", 32'(bus.o_Vld1), 32'(m1.size() > 0));
    chk("d0", 32'(bus.o_D0), m0.size() > 0 ? 32'(m0[0]) : 32'h0);
    chk("d1", 32'(bus.o_D1), m1.size() > 0 ? 32'(m1[0]) : 32'h0);
    chk("cnt0", 32'(bus.o_Cnt0), 32'(m0.size()));
    chk("cnt1", 32'(bus.o_Cnt1), 32'(m1.size()));
    chk("ready", 32'(bus.o_Ready), 32'(bus.i_Sel ? m1.size() < DEPTH : m0.size() < DEPTH));
`ifdef CAPTURE_DROP_CNT_EN
    chk("drop0", 32'(bus.o_Drop0), 32'(md0));
    chk("drop1", 32'(bus.o_Drop1), 32'(md1));
`endif
  end
  task automatic tick(input logic v, input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic r0, input logic r1);
    #1;
    bus.i_Valid = v;
    bus.i_Sel   = s;
    bus.i_X0    = a;
    bus.i_X1    = b;
    bus.i_Rdy0  = r0;
    bus.i_Rdy1  = r1;
    @(negedge clk);
  endtask
  task automatic push(input logic s, input logic [15:0] w, input logic r0, input logic r1);
    tick(1'b1, s, s ? 16'h0 : w, s ? w : 16'h0, r0, r1);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    bus.i_Valid = 0; bus.i_Sel = 0; bus.i_X0 = 0; bus.i_X1 = 0; bus.i_Rdy0 = 0; bus.i_Rdy1 = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld0", 32'(bus.o_Vld0), 0);
    chk("rst_cnt1", 32'(bus.o_Cnt1), 0);
    chk("rst_d0", 32'(bus.o_D0), 0);
    chk("rst_ready_s0", 32'(bus.o_Ready), 1);
    tick(0, 1, 0, 0, 0, 0);
    chk("rst_ready_s1", 32'(bus.o_Ready), 1);
    push(0, 16'hA5A5, 0, 0);
    chk("a5_vld0", 32'(bus.o_Vld0), 1);
    chk("a5_d0", 32'(bus.o_D0), 32'hA5A5);
    chk("a5_cnt0", 32'(bus.o_Cnt0), 1);
    chk("a5_vld1", 32'(bus.o_Vld1), 0);
    tick(0, 0, 0, 0, 1, 0);
    push(1, 16'h0001, 0, 0);
    push(1, 16'h0002, 0, 0);
    chk("l1_cnt_full", 32'(bus.o_Cnt1), 2);
    chk("l1_ready_full", 32'(bus.o_Ready), 0);
    push(1, 16'h0003, 0, 0);
    chk("l1_cnt_drop", 32'(bus.o_Cnt1), 2);
    chk("l1_head", 32'(bus.o_D1), 32'h0001);
`ifdef CAPTURE_DROP_CNT_EN
    chk("l1_drop", 32'(bus.o_Drop1), 1);
`endif
    tick(0, 1, 0, 0, 0, 1);
    chk("l1_pop1", 32'(bus.o_D1), 32'h0002);
    tick(0, 1, 0, 0, 0, 1);
    chk("l1_pop2_vld", 32'(bus.o_Vld1), 0);
    chk("l1_pop2_d", 32'(bus.o_D1), 0);
    push(0, 16'h0010, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      push(0, 16'(16'h0010 + i), 1, 0);
      chk("pp_head", 32'(bus.o_D0), 32'(16'h0010 + i));
      chk("pp_cnt", 32'(bus.o_Cnt0), 1);
    end
    tick(0, 0, 0, 0, 1, 0);
    chk("pp_drain", 32'(bus.o_Vld0), 0);
    push(0, 16'h0021, 0, 0);
    push(0, 16'h0022, 0, 0);
    push(0, 16'h0023, 1, 0);
    chk("full_pp_cnt", 32'(bus.o_Cnt0), 1);
    chk("full_pp_head", 32'(bus.o_D0), 32'h0022);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld0", 32'(bus.o_Vld0), 0);
    chk("async_cnt0", 32'(bus.o_Cnt0), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
`ifdef CAPTURE_DROP_CNT_EN
    pulse_reset();
    push(0, 16'h0031, 0, 0);
    push(0, 16'h0032, 0, 0);
    repeat (300) push(0, 16'h0033, 0, 0);
    chk("sat_drop0", 32'(bus.o_Drop0), 32'hFF);
    chk("sat_drop1", 32'(bus.o_Drop1), 0);
`endif
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 200) % 4;
      tick(1'($urandom % 4 != 0), 1'($urandom % 2), 16'($urandom), 16'($urandom),
           1'(($urandom % 4) < bias), 1'(($urandom % 4) < 3 - bias));
      if (i % 3 == 0) begin
        automatic logic s = 1'($urandom % 2);
        automatic logic [15:0] w = 16'($urandom);
        push(s, w, 1'($urandom % 2), 1'($urandom % 2));
      end
    end
    tick(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
